// File: rtl/pe_col_ctrl_pkg.sv
// Shared types and constants for the PE column controller.
// The PE step/weight-mode types match what the PE instances decode.
package pe_col_ctrl_pkg;

    localparam int STEPS_3X3 = 6;
    localparam int STEPS_5X5 = 12;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        STEP_1  = 4'd1,
        STEP_2  = 4'd2,
        STEP_3  = 4'd3,
        STEP_4  = 4'd4,
        STEP_5  = 4'd5,
        STEP_6  = 4'd6,
        STEP_7  = 4'd7,
        STEP_8  = 4'd8,
        STEP_9  = 4'd9,
        STEP_10 = 4'd10,
        STEP_11 = 4'd11,
        STEP_12 = 4'd12
    } PE_state_t;

    typedef enum logic [2:0] {
        E_MODE = 3'd0,
        A_MODE = 3'd1,
        B_MODE = 3'd2,
        C_MODE = 3'd3,
        D_MODE = 3'd4
    } PE_weight_mode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_FIN,
        S_DRAIN
    } ctrl_fsm_t;

    function automatic logic [3:0] last_step(input logic kernel5);
        return kernel5 ? 4'(STEPS_5X5) : 4'(STEPS_3X3);
    endfunction

endpackage

// File: rtl/pe_col_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner.
module pe_col_ctrl_rr_arbiter #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx
);

    logic [W-1:0] ptr;
    logic [W-1:0] idx;

    // Scan from the farthest candidate down so the nearest one wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = W'((int'(ptr) + i) % N);
            if (en && req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (grant_idx == W'(N - 1)) ? '0 : grant_idx + W'(1);
        end
    end

endmodule

// File: rtl/pe_col_ctrl.sv
// Column controller: sequences PE steps and weight modes per activation
// group, tracks row/column position, and drains PE psum FIFOs round-robin.
module pe_col_ctrl
    import pe_col_ctrl_pkg::*;
#(
    parameter int NUM_PE = 4,
    parameter int COL_W  = 8,
    parameter int ROW_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      cfg_kernel5,
    input  logic [COL_W-1:0]          cfg_row_len,
    input  logic [ROW_W-1:0]          cfg_num_rows,
    input  logic                      act_valid,
    output logic                      act_ready,
    output PE_state_t                 state,
    output PE_weight_mode_t           weight_mode,
    output logic                      weight_ld,
    output logic                      finish,
    output logic                      end_of_row,
    input  logic [NUM_PE-1:0]         pe_fifo_full,
    input  logic [NUM_PE-1:0]         pe_fifo_empty,
    output logic [NUM_PE-1:0]         pe_fifo_rd_en,
    output logic                      out_valid,
    output logic [$clog2(NUM_PE)-1:0] out_pe_id,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done
);

    ctrl_fsm_t                 fsm;
    logic [3:0]                step;
    logic [COL_W-1:0]          col;
    logic [COL_W-1:0]          row_len_q;
    logic [ROW_W-1:0]          row;
    logic [ROW_W-1:0]          num_rows_q;
    logic                      kernel5_q;
    logic                      any_full;
    logic                      step_go;
    logic                      fin_go;
    logic                      last_col;
    logic                      last_row;
    logic                      last_of_mode;
    logic                      last_mode;
    logic                      drain_ok;
    logic                      arb_en;
    logic [NUM_PE-1:0]         grant;
    logic [$clog2(NUM_PE)-1:0] grant_idx;

    assign any_full     = |pe_fifo_full;
    assign step_go      = (fsm == S_STEP) && act_valid && !any_full;
    assign fin_go       = (fsm == S_FIN) && !any_full;
    assign last_col     = (col == row_len_q - COL_W'(1));
    assign last_row     = (row == num_rows_q - ROW_W'(1));
    assign last_of_mode = (step == last_step(kernel5_q));
    assign last_mode    = (weight_mode == E_MODE) || (weight_mode == D_MODE);
    // A word still waiting on out_ready counts as an outstanding read.
    assign drain_ok     = (&pe_fifo_empty) && (!out_valid || out_ready);

    // Stalled cycles present IDLE so no PE accumulates a stale activation.
    assign act_ready  = step_go;
    assign state      = step_go ? PE_state_t'(step) : IDLE;
    assign weight_ld  = (fsm == S_LOAD);
    assign finish     = fin_go;
    assign end_of_row = fin_go && last_col;
    assign busy       = (fsm != S_IDLE);
    assign done       = (fsm == S_DRAIN) && drain_ok;

    assign arb_en        = busy && (out_ready || !out_valid);
    assign pe_fifo_rd_en = grant;

    pe_col_ctrl_rr_arbiter #(.N(NUM_PE)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (~pe_fifo_empty),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= S_IDLE;
            step        <= '0;
            col         <= '0;
            row         <= '0;
            row_len_q   <= '0;
            num_rows_q  <= '0;
            kernel5_q   <= 1'b0;
            weight_mode <= E_MODE;
        end else begin
            unique case (fsm)
                S_IDLE: if (start) begin
                    kernel5_q   <= cfg_kernel5;
                    row_len_q   <= cfg_row_len;
                    num_rows_q  <= cfg_num_rows;
                    col         <= '0;
                    row         <= '0;
                    step        <= 4'd1;
                    weight_mode <= cfg_kernel5 ? A_MODE : E_MODE;
                    fsm         <= S_LOAD;
                end
                S_LOAD: fsm <= S_STEP;
                S_STEP: if (step_go) begin
                    if (!last_of_mode) begin
                        step <= step + 4'd1;
                    end else begin
                        step <= 4'd1;
                        if (last_mode) begin
                            fsm <= S_FIN;
                        end else begin
                            weight_mode <= PE_weight_mode_t'(weight_mode + 3'd1);
                            fsm         <= S_LOAD;
                        end
                    end
                end
                S_FIN: if (fin_go) begin
                    weight_mode <= kernel5_q ? A_MODE : E_MODE;
                    if (last_col) begin
                        col <= '0;
                        if (last_row) begin
                            row <= '0;
                            fsm <= S_DRAIN;
                        end else begin
                            row <= row + ROW_W'(1);
                            fsm <= S_LOAD;
                        end
                    end else begin
                        col <= col + COL_W'(1);
                        fsm <= S_LOAD;
                    end
                end
                S_DRAIN: if (drain_ok) begin
                    weight_mode <= E_MODE;
                    fsm         <= S_IDLE;
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

    // FIFO read data appears one cycle after rd_en, so valid/id follow a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pe_id <= '0;
        end else if (|grant) begin
            out_valid <= 1'b1;
            out_pe_id <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pe_col_ctrl.sv
// Self-checking bench for pe_col_ctrl: randomized layers against a
// per-activation script model plus an idealized PE FIFO/drain model.
module tb_pe_col_ctrl;
    import pe_col_ctrl_pkg::*;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            cfg_kernel5;
    logic [7:0]      cfg_row_len;
    logic [7:0]      cfg_num_rows;
    logic            act_valid;
    logic            act_ready;
    PE_state_t       state;
    PE_weight_mode_t weight_mode;
    logic            weight_ld;
    logic            finish;
    logic            end_of_row;
    logic [N-1:0]    pe_fifo_full;
    logic [N-1:0]    pe_fifo_empty;
    logic [N-1:0]    pe_fifo_rd_en;
    logic            out_valid;
    logic [1:0]      out_pe_id;
    logic            out_ready;
    logic            busy;
    logic            done;

    always #5 clk = ~clk;

    pe_col_ctrl #(.NUM_PE(N), .COL_W(8), .ROW_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_kernel5(cfg_kernel5),
        .cfg_row_len(cfg_row_len), .cfg_num_rows(cfg_num_rows),
        .act_valid(act_valid), .act_ready(act_ready), .state(state),
        .weight_mode(weight_mode), .weight_ld(weight_ld), .finish(finish),
        .end_of_row(end_of_row), .pe_fifo_full(pe_fifo_full),
        .pe_fifo_empty(pe_fifo_empty), .pe_fifo_rd_en(pe_fifo_rd_en),
        .out_valid(out_valid), .out_pe_id(out_pe_id), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int mode;
        int step;
        bit mode_end;
        bit grp_end;
    } item_t;

    item_t exp_q[$];
    int    cnt[N];
    int    ptr_m, id_m;
    bit    ov_m;
    int    fin_cyc[$];
    int    rd_order[$];
    int    ld_count, acc_count;

    task automatic set_empty();
        for (int i = 0; i < N; i++) pe_fifo_empty[i] = (cnt[i] == 0);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (cnt[i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(state), 32'(IDLE));
        chk({tag, "_wmode"}, 32'(weight_mode), 32'(E_MODE));
        chk({tag, "_wld"}, 32'(weight_ld), 0);
        chk({tag, "_finish"}, 32'(finish), 0);
        chk({tag, "_rd_en"}, 32'(pe_fifo_rd_en), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_pe_id"}, 32'(out_pe_id), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    // One layer from the start pulse through done. vpct=200 toggles act_valid.
    task automatic run_layer(input bit k5, input int rl, input int nr, input int vpct,
                             input int fin_hold, input int full_pct, input int ready_pct,
                             input int push_pct, input int abort_at);
        int  g_tot, steps, nmodes, grp, cyc, fin_left, sel;
        bit  ld_due, fin_due, draining, finished;
        int  e_ld, e_fin, e_eor, e_done, e_rdy, e_state, e_rd;
        logic [N-1:0] rd_seen;
        item_t it;

        g_tot  = rl * nr;
        steps  = k5 ? STEPS_5X5 : STEPS_3X3;
        nmodes = k5 ? 4 : 1;
        exp_q.delete(); fin_cyc.delete(); rd_order.delete();
        ld_count = 0; acc_count = 0;
        for (int g = 0; g < g_tot; g++)
            for (int m = 0; m < nmodes; m++)
                for (int s = 1; s <= steps; s++) begin
                    it.mode     = k5 ? int'(A_MODE) + m : int'(E_MODE);
                    it.step     = s;
                    it.mode_end = (s == steps);
                    it.grp_end  = (s == steps) && (m == nmodes - 1);
                    exp_q.push_back(it);
                end

        start = 1'b1; cfg_kernel5 = k5; cfg_row_len = 8'(rl); cfg_num_rows = 8'(nr);
        act_valid = 1'b0; pe_fifo_full = '0;
        out_ready = ($urandom_range(99) < 32'(ready_pct));
        @(negedge clk);
        chk("start_busy", 32'(busy), 0);
        chk("start_rd_en", 32'(pe_fifo_rd_en), 0);
        if (out_ready) ov_m = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;

        ld_due = 1'b1; fin_due = 1'b0; draining = 1'b0; finished = 1'b0;
        grp = 0; cyc = 1; fin_left = 0;
        while (!finished && cyc <= 6000) begin
            if (abort_at != 0 && cyc == abort_at) begin
                rst_n = 1'b0; start = 1'b0; act_valid = 1'b0; pe_fifo_full = '0;
                #2;
                chk_reset_outputs("midrst");
                ptr_m = 0; ov_m = 1'b0; id_m = 0;
                @(negedge clk); chk("midrst_done", 32'(done), 0);
                @(negedge clk); chk("midrst_done2", 32'(done), 0);
                rst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            act_valid = (vpct == 200) ? ((cyc % 2) == 1) : ($urandom_range(99) < 32'(vpct));
            if (fin_due && fin_left > 0) begin
                pe_fifo_full = 4'b0100;
                fin_left--;
            end else begin
                pe_fifo_full = ($urandom_range(99) < 32'(full_pct)) ? 4'(1 << $urandom_range(3)) : 4'b0;
            end
            out_ready    = ($urandom_range(99) < 32'(ready_pct));
            cfg_kernel5  = 1'($urandom_range(1));
            cfg_row_len  = 8'($urandom_range(1, 255));
            cfg_num_rows = 8'($urandom_range(1, 255));
            start        = ($urandom_range(19) == 0);

            @(negedge clk);
            e_ld = 0; e_fin = 0; e_eor = 0; e_done = 0; e_rdy = 0; e_state = 0;
            if (ld_due) e_ld = 1;
            else if (fin_due) begin
                e_fin = (pe_fifo_full == 0);
                e_eor = e_fin && ((grp % rl) == rl - 1);
            end else if (draining) e_done = all_empty() && (!ov_m || out_ready);
            else begin
                e_rdy = act_valid && (pe_fifo_full == 0);
                if (e_rdy) e_state = exp_q[0].step;
            end
            chk("weight_ld", 32'(weight_ld), e_ld);
            chk("finish", 32'(finish), e_fin);
            chk("end_of_row", 32'(end_of_row), e_eor);
            chk("done", 32'(done), e_done);
            chk("act_ready", 32'(act_ready), e_rdy);
            chk("state", 32'(state), e_state);
            chk("busy", 32'(busy), 1);
            if (e_ld != 0 || e_rdy != 0) chk("weight_mode", 32'(weight_mode), exp_q[0].mode);

            // Drain model: one read when the output slot is free, RR from ptr_m.
            e_rd = 0; sel = -1;
            if (!ov_m || out_ready)
                for (int i = 0; i < N; i++)
                    if (sel < 0 && cnt[(ptr_m + i) % N] > 0) sel = (ptr_m + i) % N;
            if (sel >= 0) e_rd = 1 << sel;
            chk("rd_en", 32'(pe_fifo_rd_en), e_rd);
            chk("out_valid", 32'(out_valid), 32'(ov_m));
            if (ov_m) chk("out_pe_id", 32'(out_pe_id), id_m);
            if (sel >= 0) begin
                ov_m = 1'b1; id_m = sel; ptr_m = (sel + 1) % N;
                rd_order.push_back(sel);
            end else if (out_ready) ov_m = 1'b0;
            rd_seen = pe_fifo_rd_en;
            if (weight_ld) ld_count++;
            if (finish) fin_cyc.push_back(cyc);
            if (act_ready) acc_count++;

            if (ld_due) ld_due = 1'b0;
            else if (fin_due) begin
                if (e_fin != 0) begin
                    grp++; fin_due = 1'b0;
                    if (grp == g_tot) draining = 1'b1; else ld_due = 1'b1;
                end
            end else if (draining) begin
                if (e_done != 0) finished = 1'b1;
            end else if (e_rdy != 0) begin
                it = exp_q.pop_front();
                if (it.grp_end) begin fin_due = 1'b1; fin_left = fin_hold; end
                else if (it.mode_end) ld_due = 1'b1;
            end

            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (rd_seen[i] && cnt[i] > 0) cnt[i]--;
                if (!draining && cnt[i] < 15 && $urandom_range(99) < 32'(push_pct)) cnt[i]++;
            end
            set_empty();
            cyc++;
        end
        if (!finished) chk("layer_timeout", 0, 1);
        start = 1'b0; act_valid = 1'b0; pe_fifo_full = '0;
        @(negedge clk);
        chk("post_busy", 32'(busy), 0);
        chk("post_done", 32'(done), 0);
        chk("post_out_valid", 32'(out_valid), 0);
        chk("acts_total", 32'(acc_count), g_tot * steps * nmodes);
        chk("wld_total", 32'(ld_count), g_tot * nmodes);
        chk("finish_total", 32'(fin_cyc.size()), g_tot);
        if (out_ready) ov_m = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_kernel5 = 1'b0; cfg_row_len = 8'd1;
        cfg_num_rows = 8'd1; act_valid = 1'b0; pe_fifo_full = '0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        set_empty();
        ptr_m = 0; id_m = 0; ov_m = 1'b0;
        #3;
        chk_reset_outputs("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 3x3, two groups in one row, FIFOs all holding data, always ready.
        for (int i = 0; i < N; i++) cnt[i] = 5;
        set_empty();
        run_layer(1'b0, 2, 1, 100, 0, 0, 100, 0, 0);
        chk("fin_count_3x3", 32'(fin_cyc.size()), 2);
        if (fin_cyc.size() == 2) begin
            chk("fin_cyc0", 32'(fin_cyc[0]), 8);
            chk("fin_cyc1", 32'(fin_cyc[1]), 16);
        end
        chk("rd_order_len", 32'(rd_order.size() >= 5), 1);
        if (rd_order.size() >= 5) begin
            chk("rd_order0", 32'(rd_order[0]), 0);
            chk("rd_order1", 32'(rd_order[1]), 1);
            chk("rd_order2", 32'(rd_order[2]), 2);
            chk("rd_order3", 32'(rd_order[3]), 3);
            chk("rd_order4", 32'(rd_order[4]), 0);
        end

        // 5x5, single group: A..D, four weight loads.
        run_layer(1'b1, 1, 1, 100, 0, 0, 100, 0, 0);

        // Toggling activations over several rows.
        run_layer(1'b0, 3, 2, 200, 0, 0, 80, 20, 0);

        // FIFO full held during finish, plus random full stalls.
        run_layer(1'b0, 2, 2, 90, 3, 20, 70, 20, 0);

        // Reset mid-layer, then a clean layer.
        run_layer(1'b1, 2, 2, 90, 0, 0, 70, 20, 20);
        chk("after_midrst_busy", 32'(busy), 0);
        run_layer(1'b0, 1, 1, 100, 0, 0, 100, 0, 0);

        for (int l = 0; l < 8; l++)
            run_layer(1'($urandom_range(1)), int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
                      75, int'($urandom_range(2)), 10, 60, 30, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
